// File: rtl/brownout_pkg.sv
// rtl/brownout_pkg.sv - shared state type and debounce length table for brownout_filt
package brownout_pkg;

  typedef enum logic [1:0] {
    GOOD         = 2'd0,
    ASSERT_PEND  = 2'd1,
    BROWN        = 2'd2,
    RELEASE_PEND = 2'd3
  } brout_state_t;

  // Terminal debounce count (N-1) indexed by filt_cfg: N = 4, 16, 64, 256
  localparam logic [3:0][7:0] DEB_LIM = {8'd255, 8'd63, 8'd15, 8'd3};

endpackage

// File: rtl/brownout_sync.sv
// rtl/brownout_sync.sv - multi-flop synchronizer with asynchronous active-low clear to 0
module brownout_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic clr_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge clr_ni) begin
    if (!clr_ni) sync_q <= '0;
    else         sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/brownout_filt.sv
// rtl/brownout_filt.sv - brown-out comparator debounce filter with sticky flag and event counter
// Define BROWNOUT_FILT_EVCNT_EN to build the event counter; otherwise event_cnt is tied to 0.
module brownout_filt
  import brownout_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int EVCNT_W     = 8
) (
  input  logic               osc_ck,
  input  logic               ena,
  input  logic               brout_raw,
  input  logic [1:0]         filt_cfg,
  input  logic               clr_status,
  output logic               brout_filt,
  output logic               brout_sticky,
  output logic [EVCNT_W-1:0] event_cnt,
  output logic               filt_busy
);

  logic         brout_s;
  brout_state_t state_q, state_d;
  logic [7:0]   dcnt_q, dcnt_d;
  logic [7:0]   lim;
  logic         filt_q, filt_d;
  logic         sticky_q, sticky_d;
  logic         entry;

  brownout_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk_i  (osc_ck),
    .clr_ni (ena),
    .d_i    (brout_raw),
    .q_o    (brout_s)
  );

  assign lim = DEB_LIM[filt_cfg];

  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    case (state_q)
      GOOD: begin
        if (brout_s) begin
          state_d = ASSERT_PEND;
          dcnt_d  = '0;
        end
      end
      ASSERT_PEND: begin
        if (!brout_s)           state_d = GOOD;
        else if (dcnt_q >= lim) state_d = BROWN;
        else                    dcnt_d  = dcnt_q + 8'd1;
      end
      BROWN: begin
        if (!brout_s) begin
          state_d = RELEASE_PEND;
          dcnt_d  = '0;
        end
      end
      RELEASE_PEND: begin
        if (brout_s)            state_d = BROWN;
        else if (dcnt_q >= lim) state_d = GOOD;
        else                    dcnt_d  = dcnt_q + 8'd1;
      end
      default: state_d = GOOD;
    endcase

    // Only a fresh entry from GOOD counts; a release bounce back to BROWN does not
    entry    = (state_q == ASSERT_PEND) && (state_d == BROWN);
    filt_d   = (state_d == BROWN) || (state_d == RELEASE_PEND);
    sticky_d = entry | (sticky_q & ~clr_status);
  end

  always_ff @(posedge osc_ck or negedge ena) begin
    if (!ena) begin
      state_q  <= GOOD;
      dcnt_q   <= '0;
      filt_q   <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      dcnt_q   <= dcnt_d;
      filt_q   <= filt_d;
      sticky_q <= sticky_d;
    end
  end

  assign brout_filt   = filt_q;
  assign brout_sticky = sticky_q;
  assign filt_busy    = (state_q == ASSERT_PEND) || (state_q == RELEASE_PEND);

`ifdef BROWNOUT_FILT_EVCNT_EN
  logic [EVCNT_W-1:0] evcnt_q, evcnt_d;

  // A clear coinciding with an entry keeps that entry, so the count restarts at 1
  always_comb begin
    evcnt_d = evcnt_q;
    if (entry) begin
      if (clr_status)    evcnt_d = EVCNT_W'(1);
      else if (!(&evcnt_q)) evcnt_d = evcnt_q + EVCNT_W'(1);
    end else if (clr_status) begin
      evcnt_d = '0;
    end
  end

  always_ff @(posedge osc_ck or negedge ena) begin
    if (!ena) evcnt_q <= '0;
    else      evcnt_q <= evcnt_d;
  end

  assign event_cnt = evcnt_q;
`else
  assign event_cnt = '0;
`endif

endmodule

// File: tb/tb_brownout_filt.sv
// tb/tb_brownout_filt.sv - directed self-checking bench for brownout_filt
module tb_brownout_filt;

`ifdef BROWNOUT_FILT_EVCNT_EN
  localparam bit EVC = 1'b1;
`else
  localparam bit EVC = 1'b0;
`endif

  logic       osc_ck     = 1'b0;
  logic       ena        = 1'b0;
  logic       brout_raw  = 1'b0;
  logic [1:0] filt_cfg   = 2'd0;
  logic       clr_status = 1'b0;
  logic       brout_filt;
  logic       brout_sticky;
  logic [7:0] event_cnt;
  logic       filt_busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 osc_ck = ~osc_ck;

  brownout_filt #(.SYNC_STAGES(2), .EVCNT_W(8)) dut (
    .osc_ck       (osc_ck),
    .ena          (ena),
    .brout_raw    (brout_raw),
    .filt_cfg     (filt_cfg),
    .clr_status   (clr_status),
    .brout_filt   (brout_filt),
    .brout_sticky (brout_sticky),
    .event_cnt    (event_cnt),
    .filt_busy    (filt_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge osc_ck);
  endtask

  function automatic logic [31:0] ec(input int n);
    return EVC ? n : 0;
  endfunction

  initial begin
    int seen0;
    int busy_seen;
    int filt_seen;

    cyc(2);
    check("rst_filt", brout_filt, 0);
    check("rst_sticky", brout_sticky, 0);
    check("rst_cnt", event_cnt, 0);
    check("rst_busy", filt_busy, 0);
    ena = 1'b1;
    cyc(3);

    // N=4: filter rises 7 cycles after a clean rise and falls 7 after the fall
    brout_raw = 1'b1;
    cyc(6);
    check("rise_pre", brout_filt, 0);
    check("rise_busy", filt_busy, 1);
    cyc(1);
    check("rise_edge", brout_filt, 1);
    check("rise_sticky", brout_sticky, 1);
    check("rise_cnt", event_cnt, ec(1));
    check("rise_busy_off", filt_busy, 0);
    cyc(13);
    brout_raw = 1'b0;
    cyc(6);
    check("fall_pre", brout_filt, 1);
    check("fall_busy", filt_busy, 1);
    cyc(1);
    check("fall_edge", brout_filt, 0);
    cyc(3);

    // release bounce inside BROWN must not drop the output or count
    brout_raw = 1'b1;
    cyc(10);
    check("bnc_brown", brout_filt, 1);
    check("bnc_cnt0", event_cnt, ec(2));
    seen0 = 0;
    brout_raw = 1'b0;
    for (int i = 0; i < 2; i++) begin cyc(1); if (!brout_filt) seen0++; end
    brout_raw = 1'b1;
    for (int i = 0; i < 3; i++) begin cyc(1); if (!brout_filt) seen0++; end
    brout_raw = 1'b0;
    for (int i = 0; i < 6; i++) begin cyc(1); if (!brout_filt) seen0++; end
    check("bnc_hold", seen0, 0);
    cyc(1);
    check("bnc_fall", brout_filt, 0);
    check("bnc_cnt", event_cnt, ec(2));
    cyc(3);

    // N=16 glitch of 10 cycles is rejected
    filt_cfg  = 2'd1;
    busy_seen = 0;
    filt_seen = 0;
    brout_raw = 1'b1;
    for (int i = 0; i < 10; i++) begin cyc(1); busy_seen += filt_busy; filt_seen += brout_filt; end
    brout_raw = 1'b0;
    for (int i = 0; i < 20; i++) begin cyc(1); busy_seen += filt_busy; filt_seen += brout_filt; end
    check("glt_filt", filt_seen, 0);
    check("glt_busy_seen", busy_seen != 0, 1);
    check("glt_busy_end", filt_busy, 0);
    check("glt_cnt", event_cnt, ec(2));

    // shrinking N mid-debounce completes on the next cycle
    filt_cfg  = 2'd3;
    brout_raw = 1'b1;
    cyc(23);
    check("cfg_pre", brout_filt, 0);
    filt_cfg = 2'd0;
    cyc(1);
    check("cfg_done", brout_filt, 1);
    check("cfg_cnt", event_cnt, ec(3));
    brout_raw = 1'b0;
    cyc(10);
    check("cfg_rel", brout_filt, 0);

    clr_status = 1'b1;
    cyc(1);
    clr_status = 1'b0;
    check("clr_sticky", brout_sticky, 0);
    check("clr_cnt", event_cnt, 0);

    // saturation, then clear coincident with a new entry
    for (int k = 0; k < 300; k++) begin
      brout_raw = 1'b1;
      cyc(10);
      brout_raw = 1'b0;
      cyc(10);
    end
    check("sat_cnt", event_cnt, ec(255));
    check("sat_sticky", brout_sticky, 1);
    brout_raw = 1'b1;
    cyc(6);
    clr_status = 1'b1;
    cyc(1);
    clr_status = 1'b0;
    check("clrinc_cnt", event_cnt, ec(1));
    check("clrinc_sticky", brout_sticky, 1);
    check("clrinc_filt", brout_filt, 1);
    brout_raw = 1'b0;
    cyc(10);

    // enable drop mid-debounce discards all progress
    filt_cfg  = 2'd3;
    brout_raw = 1'b1;
    cyc(53);
    check("ena_busy", filt_busy, 1);
    ena = 1'b0;
    #1;
    check("ena_filt", brout_filt, 0);
    check("ena_sticky", brout_sticky, 0);
    check("ena_cnt", event_cnt, 0);
    check("ena_busy0", filt_busy, 0);
    cyc(2);
    ena = 1'b1;
    cyc(258);
    check("reena_pre", brout_filt, 0);
    cyc(1);
    check("reena_rise", brout_filt, 1);
    check("reena_sticky", brout_sticky, 1);
    check("reena_cnt", event_cnt, ec(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
